video_pattern_gen: RTL and testbench
====================================

# video_pattern_gen

Synthesizable raster source producing vs/hs/de timing plus 8-bit RGB test patterns for a configurable video mode (default 1920x1080, CEA-861 1080p60 blanking). Sits directly upstream of the simulation image writer and of the image-processing stages. It drives the same vs/hs/de/r/g/b bus those blocks consume, so any pipeline can be exercised without an external video source.

## Interface
- H_ACTIVE, 1920, active pixels per line
- H_FP, 88, horizontal front porch (clocks)
- H_SYNC, 44, hsync width (clocks)
- H_BP, 148, horizontal back porch (clocks)
- V_ACTIVE, 1080, active lines per frame
- V_FP, 4, vertical front porch (lines)
- V_SYNC, 5, vsync width (lines)
- V_BP, 36, vertical back porch (lines)

Ports:
- clk  in  1  pixel clock
- rst  in  1  reset, asynchronous, active-high
- en  in  1  run request
- pattern_sel  in  2  0 colour bars, 1 gray ramp, 2 checkerboard, 3 frame-count fill
- vs_out  out  1  vertical sync, active-high
- hs_out  out  1  horizontal sync, active-high
- de_out  out  1  data enable (active pixel)
- r_out, g_out, b_out  out  8 each  pixel colour, 0 when de_out=0
- frame_cnt  out  8  completed-frame counter, wraps 255->0
- busy  out  1  high while a frame is in progress

## Operation
- Counters:
  - h_cnt runs 0..H_TOTAL-1 with H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
  - v_cnt runs 0..V_TOTAL-1 and increments when h_cnt wraps.
  - Widths are $clog2 of the totals.
- Line order: active, then front porch, sync, back porch.
  - Active: h_cnt < H_ACTIVE.
  - hsync: H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - Vertical sequence uses the same rule on v_cnt.
- Output conditions: de = h-active AND v-active. hs is asserted on every line, including vertical blanking.
- FSM:
  - IDLE: counters held at 0, all outputs 0, busy=0. Goes to RUN when en=1.
  - RUN: counters advance every clk, busy=1.
    - At the last pixel of a frame (h=H_TOTAL-1, v=V_TOTAL-1): frame_cnt increments. Go to IDLE if en=0, else stay in RUN and wrap to (0,0).
  - en falling mid-frame has no effect until frame end. Frames always complete.
- pattern_sel is latched at frame start (entry to (0,0) from IDLE or wrap). Changes mid-frame are ignored.
- Patterns, where x=h_cnt and y=v_cnt:
  - 0, colour bars: 8 equal bars of width H_ACTIVE/8. Bar index k = x/(H_ACTIVE/8), clamped to 7. r = k[2]?FF:00, g = k[1]?FF:00, b = k[0]?FF:00. Order is black,blue,green,cyan,red,magenta,yellow,white.
  - 1, gray ramp: r=g=b=x[10:3] (x[7:0] when H_ACTIVE<=256).
  - 2, checkerboard: 64x64 cells. r=g=b = (x[6]^y[6]) ? FF : 00.
  - 3, fill: r=frame_cnt, g=~frame_cnt, b=8'h80.
- Bar index division is done by comparison against precomputed constant boundaries. No divider.

## Timing
- All outputs are registered, with a single cycle latency from counter state. vs/hs/de/rgb for pixel (x,y) appear the clk after h_cnt=x, v_cnt=y, and are mutually aligned.
- First de_out rises 1 clk after the RUN entry edge. The IDLE->RUN transition costs one clk.
- Reset (async, any time, including mid-frame): IDLE, counters 0, all outputs 0, frame_cnt 0, latched pattern 0. Release resumes at IDLE.
- frame_cnt updates on the same edge the counters wrap, so it is visible with the first pixel of the next frame.
- busy drops on the edge that returns to IDLE. Outputs are 0 from the next clk onward.

## Structure
- A shared package `video_pkg` holds the pattern_sel encodings, the FSM state enum, and the default 1080p timing constants. Neighbouring stages reuse these.
- One sub-module, `video_timing_core`. It contains the counters, sync/de decode and FSM, and exports h_cnt/v_cnt/active flags. The top adds the pattern generator and output registers.

## Test plan
All scenarios use a small mode: H_ACTIVE=16, H_FP=2, H_SYNC=2, H_BP=4, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=2.
- Basic timing: en=1 for 2 frames.
  - Expect 24 clk per line, 8 lines per frame, 64 de clk per frame.
  - hs high for 2 clk starting 18 clk after de rises on each line. vs high for exactly 24 clk per frame.
- Colour bars: pattern 0, one active line.
  - Expect 8 runs of 2 pixels: 000000,0000FF,00FF00,00FFFF,FF0000,FF00FF,FFFF00,FFFFFF.
- Stop at frame end: deassert en at line 2 of frame 0.
  - Frame completes with 64 de clk, frame_cnt=1, then busy=0 and all outputs 0.
- Mid-frame pattern change: switch 0->2 mid-frame.
  - Current frame stays bars. Next frame is checkerboard.
- Async reset: assert rst mid-line with de=1.
  - Outputs go 0 without waiting for clk. frame_cnt=0.
  - After release plus en, the first de appears at the correct (0,0) timing.
- Wrap: run 256 frames with pattern 3.
  - frame_cnt goes 255->0. The fill for frame 256 is r=00, g=FF, b=80.

Source files
------------

// File: rtl/video_pkg.sv
// Shared video definitions: pattern encodings, raster FSM states, default 1080p60 timing.
package video_pkg;

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_GRAY  = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_FILL  = 2'd3
    } pattern_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // CEA-861 1080p60 blanking
    localparam int DEF_H_ACTIVE = 1920;
    localparam int DEF_H_FP     = 88;
    localparam int DEF_H_SYNC   = 44;
    localparam int DEF_H_BP     = 148;
    localparam int DEF_V_ACTIVE = 1080;
    localparam int DEF_V_FP     = 4;
    localparam int DEF_V_SYNC   = 5;
    localparam int DEF_V_BP     = 36;

endpackage

// File: rtl/video_timing_core.sv
// Raster counters, sync/active decode and the IDLE/RUN frame FSM.
module video_timing_core
    import video_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW      = $clog2(H_TOTAL),
    localparam int VW      = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic [HW-1:0] h_cnt,
    output logic [VW-1:0] v_cnt,
    output logic          h_active,
    output logic          v_active,
    output logic          h_sync,
    output logic          v_sync,
    output logic          running,
    output logic          frame_start,
    output logic [7:0]    frame_cnt
);

    state_e state;
    logic   h_last, v_last;

    assign h_last = (h_cnt == HW'(H_TOTAL - 1));
    assign v_last = (v_cnt == VW'(V_TOTAL - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            h_cnt     <= '0;
            v_cnt     <= '0;
            frame_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    h_cnt <= '0;
                    v_cnt <= '0;
                    if (en) state <= ST_RUN;
                end
                ST_RUN: begin
                    if (!h_last) begin
                        h_cnt <= h_cnt + 1'b1;
                    end else begin
                        h_cnt <= '0;
                        if (!v_last) begin
                            v_cnt <= v_cnt + 1'b1;
                        end else begin
                            // en is only honoured here, so frames always complete
                            v_cnt     <= '0;
                            frame_cnt <= frame_cnt + 1'b1;
                            if (!en) state <= ST_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign running = (state == ST_RUN);

    // Counters land on (0,0) at the next edge: from IDLE on a run request or on wrap
    assign frame_start = running ? (h_last && v_last) : en;

    assign h_active = (h_cnt < HW'(H_ACTIVE));
    assign v_active = (v_cnt < VW'(V_ACTIVE));
    assign h_sync   = (h_cnt >= HW'(H_ACTIVE + H_FP)) && (h_cnt < HW'(H_ACTIVE + H_FP + H_SYNC));
    assign v_sync   = (v_cnt >= VW'(V_ACTIVE + V_FP)) && (v_cnt < VW'(V_ACTIVE + V_FP + V_SYNC));

endmodule

// File: rtl/video_pattern_gen.sv
// Test-pattern raster source: timing core plus pattern generator and aligned output registers.
module video_pattern_gen
    import video_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] pattern_sel,
    output logic       vs_out,
    output logic       hs_out,
    output logic       de_out,
    output logic [7:0] r_out,
    output logic [7:0] g_out,
    output logic [7:0] b_out,
    output logic [7:0] frame_cnt,
    output logic       busy
);

    localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW         = $clog2(H_TOTAL);
    localparam int VW         = $clog2(V_TOTAL);
    localparam int BAR_W      = H_ACTIVE / 8;
    localparam int GRAY_SHIFT = (H_ACTIVE <= 256) ? 0 : 3;

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          h_active, v_active, h_sync, v_sync;
    logic          running, frame_start;

    video_timing_core #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_core (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .h_active    (h_active),
        .v_active    (v_active),
        .h_sync      (h_sync),
        .v_sync      (v_sync),
        .running     (running),
        .frame_start (frame_start),
        .frame_cnt   (frame_cnt)
    );

    pattern_e pat_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)              pat_q <= PAT_BARS;
        else if (frame_start) pat_q <= pattern_e'(pattern_sel);
    end

    logic [2:0] bar;
    logic [7:0] gray, chk;
    rgb_t       pix;

    always_comb begin
        // bar index by comparison against fixed boundaries; last bar absorbs any remainder
        bar = '0;
        for (int i = 1; i < 8; i++)
            if (32'(h_cnt) >= 32'(i * BAR_W)) bar = 3'(i);
        gray = 8'(32'(h_cnt) >> GRAY_SHIFT);
        chk  = ((32'(h_cnt) ^ 32'(v_cnt)) & 32'h40) != 0 ? 8'hFF : 8'h00;
        pix  = '0;
        case (pat_q)
            PAT_BARS:  pix = '{r: {8{bar[2]}}, g: {8{bar[1]}}, b: {8{bar[0]}}};
            PAT_GRAY:  pix = '{r: gray, g: gray, b: gray};
            PAT_CHECK: pix = '{r: chk, g: chk, b: chk};
            PAT_FILL:  pix = '{r: frame_cnt, g: ~frame_cnt, b: 8'h80};
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_out <= 1'b0;
            hs_out <= 1'b0;
            de_out <= 1'b0;
            r_out  <= '0;
            g_out  <= '0;
            b_out  <= '0;
        end else if (running) begin
            vs_out <= v_sync;
            hs_out <= h_sync;
            de_out <= h_active && v_active;
            {r_out, g_out, b_out} <= (h_active && v_active) ? pix : '0;
        end else begin
            vs_out <= 1'b0;
            hs_out <= 1'b0;
            de_out <= 1'b0;
            r_out  <= '0;
            g_out  <= '0;
            b_out  <= '0;
        end
    end

    assign busy = running;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen in a 16x4 mode: cycle scoreboard plus per-scenario checks.
module tb_video_pattern_gen;

    localparam int HA = 16, HFP = 2, HS = 2, HBP = 4;
    localparam int VA = 4,  VFP = 1, VS = 1, VBP = 2;
    localparam int HT = HA + HFP + HS + HBP;   // 24
    localparam int VT = VA + VFP + VS + VBP;   // 8
    localparam int FR = HT * VT;               // 192

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [1:0] pattern_sel = 2'd0;
    logic       vs_out, hs_out, de_out, busy;
    logic [7:0] r_out, g_out, b_out, frame_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic       vs;
        logic       hs;
        logic       de;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic [7:0] fc;
        logic       busy;
    } obs_t;

    obs_t got;
    obs_t sb[$];
    obs_t cap[$];
    obs_t e, exp_o;

    video_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .pattern_sel (pattern_sel),
        .vs_out      (vs_out),
        .hs_out      (hs_out),
        .de_out      (de_out),
        .r_out       (r_out),
        .g_out       (g_out),
        .b_out       (b_out),
        .frame_cnt   (frame_cnt),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    assign got = {vs_out, hs_out, de_out, r_out, g_out, b_out, frame_cnt, busy};

    function automatic logic [23:0] exp_pix(input logic [1:0] p, input int x, input int y,
                                            input logic [7:0] fc);
        int k;
        logic [7:0] v;
        case (p)
            2'd0: begin
                k = x / (HA / 8);
                if (k > 7) k = 7;
                return {{8{k[2]}}, {8{k[1]}}, {8{k[0]}}};
            end
            2'd1: begin
                v = (HA <= 256) ? 8'(x) : 8'(x >> 3);
                return {v, v, v};
            end
            2'd2: begin
                v = (((x >> 6) ^ (y >> 6)) & 1) != 0 ? 8'hFF : 8'h00;
                return {v, v, v};
            end
            default: return {fc, ~fc, 8'h80};
        endcase
    endfunction

    // Behavioural model: expected output after each edge is pushed at that edge
    bit         m_run = 0;
    int         mx = 0, my = 0;
    logic [7:0] mfc = 0;
    logic [1:0] mpat = 0;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_run = 0; mx = 0; my = 0; mfc = 0; mpat = 0;
            sb.delete();
        end else begin
            e = '0;
            if (m_run) begin
                e.de = (mx < HA) && (my < VA);
                e.hs = (mx >= HA + HFP) && (mx < HA + HFP + HS);
                e.vs = (my >= VA + VFP) && (my < VA + VFP + VS);
                if (e.de) {e.r, e.g, e.b} = exp_pix(mpat, mx, my, mfc);
            end
            if (!m_run) begin
                if (en) begin m_run = 1; mx = 0; my = 0; mpat = pattern_sel; end
            end else if (mx == HT - 1) begin
                mx = 0;
                if (my == VT - 1) begin
                    my = 0; mfc = mfc + 8'd1; mpat = pattern_sel;
                    if (!en) m_run = 0;
                end else my = my + 1;
            end else mx = mx + 1;
            e.fc   = mfc;
            e.busy = m_run;
            sb.push_back(e);
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst && sb.size() > 0) begin
            exp_o = sb.pop_front();
            n_tests++;
            if (got !== exp_o) begin
                n_fail++;
                $display("FAIL scoreboard t=%0t got=%h exp=%h", $time, got, exp_o);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Samples one value per negedge; optionally changes inputs after sample chg_at
    task automatic capture(input int n, input int chg_at, input logic chg_en, input logic [1:0] chg_pat);
        cap.delete();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cap.push_back(got);
            if (i == chg_at) begin en = chg_en; pattern_sel = chg_pat; end
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 500) begin @(negedge clk); t++; end
        n_tests++;
        if (busy) begin n_fail++; $display("FAIL wait_idle timeout busy=%0b req=0", busy); end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_tests++;
        if (got !== '0) begin n_fail++; $display("FAIL reset_state got=%h exp=0", got); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (got !== '0) begin n_fail++; $display("FAIL idle_state got=%h exp=0", got); end
    endtask

    task automatic test_stop_at_frame_end();
        int de_n = 0, busy_n = 0;
        en = 1'b1; pattern_sel = 2'd0;
        capture(200, 48, 1'b0, 2'd0);
        foreach (cap[i]) begin
            if (cap[i].de)   de_n++;
            if (cap[i].busy) busy_n++;
        end
        n_tests++;
        if (de_n !== 64) begin n_fail++; $display("FAIL stop_de_count got=%0d exp=64", de_n); end
        n_tests++;
        if (busy_n !== FR) begin n_fail++; $display("FAIL stop_busy_len got=%0d exp=%0d", busy_n, FR); end
        n_tests++;
        if (cap[FR].fc !== 8'd1 || cap[FR].busy !== 1'b0) begin
            n_fail++; $display("FAIL stop_frame_cnt got=%0d busy=%0b exp=1 busy=0", cap[FR].fc, cap[FR].busy);
        end
        exp_o = '0; exp_o.fc = 8'd1;
        n_tests++;
        if (cap[FR+1] !== exp_o) begin n_fail++; $display("FAIL stop_outputs_zero got=%h exp=%h", cap[FR+1], exp_o); end
        wait_idle();
    endtask

    task automatic test_basic_timing();
        int first_de = -1, de0 = 0, de1 = 0, vs0 = 0, vs1 = 0;
        int rises[$];
        en = 1'b1; pattern_sel = 2'd0;
        capture(390, 250, 1'b0, 2'd0);
        foreach (cap[i]) begin
            if (cap[i].de && first_de < 0) first_de = i;
            if (cap[i].de && (i == 0 || !cap[i-1].de)) rises.push_back(i);
            if (i >= 1 && i <= FR) begin
                if (cap[i].de) de0++;
                if (cap[i].vs) vs0++;
            end else if (i > FR && i <= 2 * FR) begin
                if (cap[i].de) de1++;
                if (cap[i].vs) vs1++;
            end
        end
        n_tests++;
        if (first_de !== 1) begin n_fail++; $display("FAIL first_de_latency got=%0d exp=1", first_de); end
        n_tests++;
        if (de0 !== 64 || de1 !== 64) begin n_fail++; $display("FAIL de_per_frame got=%0d,%0d exp=64,64", de0, de1); end
        n_tests++;
        if (vs0 !== HT || vs1 !== HT) begin n_fail++; $display("FAIL vs_per_frame got=%0d,%0d exp=%0d", vs0, vs1, HT); end
        n_tests++;
        if (cap[120].vs !== 1'b0 || cap[121].vs !== 1'b1) begin
            n_fail++; $display("FAIL vs_start got=%0b%0b exp=01", cap[120].vs, cap[121].vs);
        end
        n_tests++;
        if (rises.size() !== 8) begin n_fail++; $display("FAIL de_rises got=%0d exp=8", rises.size()); end
        else begin
            n_tests++;
            if (rises[3] - rises[0] !== 3 * HT) begin
                n_fail++; $display("FAIL line_period got=%0d exp=%0d", rises[3] - rises[0], 3 * HT);
            end
        end
        for (int k = 0; k < 2 * VT; k++) begin
            int l = 1 + k * HT;
            n_tests++;
            if ({cap[l+17].hs, cap[l+18].hs, cap[l+19].hs, cap[l+20].hs} !== 4'b0110) begin
                n_fail++;
                $display("FAIL hs_line%0d got=%b exp=0110", k, {cap[l+17].hs, cap[l+18].hs, cap[l+19].hs, cap[l+20].hs});
            end
        end
        wait_idle();
    endtask

    task automatic test_colour_bars();
        logic [23:0] bars [8];
        bars = '{24'h000000, 24'h0000FF, 24'h00FF00, 24'h00FFFF,
                 24'hFF0000, 24'hFF00FF, 24'hFFFF00, 24'hFFFFFF};
        en = 1'b1; pattern_sel = 2'd0;
        capture(30, 5, 1'b0, 2'd0);
        for (int x = 0; x < HA; x++) begin
            n_tests++;
            if ({cap[1+x].r, cap[1+x].g, cap[1+x].b} !== bars[x/2] || cap[1+x].de !== 1'b1) begin
                n_fail++;
                $display("FAIL bars_x%0d got=%h de=%0b exp=%h", x, {cap[1+x].r, cap[1+x].g, cap[1+x].b}, cap[1+x].de, bars[x/2]);
            end
        end
        wait_idle();
    endtask

    task automatic test_pattern_change();
        logic [23:0] bars [8];
        bars = '{24'h000000, 24'h0000FF, 24'h00FF00, 24'h00FFFF,
                 24'hFF0000, 24'hFF00FF, 24'hFFFF00, 24'hFFFFFF};
        en = 1'b1; pattern_sel = 2'd0;
        capture(260, 50, 1'b1, 2'd2);
        en = 1'b0;
        for (int x = 0; x < HA; x++) begin
            n_tests++;
            if ({cap[73+x].r, cap[73+x].g, cap[73+x].b} !== bars[x/2]) begin
                n_fail++; $display("FAIL chg_frame0_x%0d got=%h exp=%h", x, {cap[73+x].r, cap[73+x].g, cap[73+x].b}, bars[x/2]);
            end
            n_tests++;
            if ({cap[FR+1+x].r, cap[FR+1+x].g, cap[FR+1+x].b} !== 24'h000000 || cap[FR+1+x].de !== 1'b1) begin
                n_fail++; $display("FAIL chg_frame1_x%0d got=%h exp=000000", x, {cap[FR+1+x].r, cap[FR+1+x].g, cap[FR+1+x].b});
            end
        end
        wait_idle();
    endtask

    task automatic test_async_reset();
        int first_de = -1;
        en = 1'b1; pattern_sel = 2'd0;
        capture(31, -1, 1'b1, 2'd0);
        n_tests++;
        if (cap[30].de !== 1'b1) begin n_fail++; $display("FAIL pre_reset_de got=%0b exp=1", cap[30].de); end
        #2;
        rst = 1'b1; en = 1'b0;
        #1;
        n_tests++;
        if (got !== '0) begin n_fail++; $display("FAIL async_reset_clear got=%h exp=0", got); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (got !== '0) begin n_fail++; $display("FAIL post_reset_idle got=%h exp=0", got); end
        en = 1'b1;
        capture(30, 2, 1'b0, 2'd0);
        foreach (cap[i]) if (cap[i].de && first_de < 0) first_de = i;
        n_tests++;
        if (first_de !== 1) begin n_fail++; $display("FAIL post_reset_first_de got=%0d exp=1", first_de); end
        exp_o = '0; exp_o.de = 1'b1; exp_o.busy = 1'b1;
        n_tests++;
        if (cap[1] !== exp_o) begin n_fail++; $display("FAIL post_reset_pixel00 got=%h exp=%h", cap[1], exp_o); end
        wait_idle();
    endtask

    task automatic test_wrap();
        obs_t x255, x256;
        x255 = '{vs: 1'b0, hs: 1'b0, de: 1'b1, r: 8'hFF, g: 8'h00, b: 8'h80, fc: 8'hFF, busy: 1'b1};
        x256 = '{vs: 1'b0, hs: 1'b0, de: 1'b1, r: 8'h00, g: 8'hFF, b: 8'h80, fc: 8'h00, busy: 1'b1};
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        en = 1'b1; pattern_sel = 2'd3;
        for (int i = 0; i <= 256 * FR + 8; i++) begin
            @(negedge clk);
            if (i == 1 + 255 * FR) begin
                n_tests++;
                if (got !== x255) begin n_fail++; $display("FAIL wrap_frame255 got=%h exp=%h", got, x255); end
            end
            if (i == 256 * FR - 1) begin
                n_tests++;
                if (frame_cnt !== 8'd255) begin n_fail++; $display("FAIL wrap_cnt255 got=%0d exp=255", frame_cnt); end
            end
            if (i == 256 * FR) begin
                n_tests++;
                if (frame_cnt !== 8'd0) begin n_fail++; $display("FAIL wrap_cnt0 got=%0d exp=0", frame_cnt); end
            end
            if (i == 1 + 256 * FR) begin
                n_tests++;
                if (got !== x256) begin n_fail++; $display("FAIL wrap_frame256 got=%h exp=%h", got, x256); end
            end
            if (i == 256 * FR + 3) en = 1'b0;
        end
        wait_idle();
    endtask

    initial begin
        test_reset();
        test_stop_at_frame_end();
        test_basic_timing();
        test_colour_bars();
        test_pattern_change();
        test_async_reset();
        test_wrap();
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
